// File: rtl/cb_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cb_cfg_pkg
//  Description : Shared constants for the connection-box configuration
//                loader: frame width, controller state encoding and the
//                layout of the select fields inside one 10-bit frame.
//  Revision    : 1.0  initial release
// ============================================================================
package cb_cfg_pkg;

    // Select bits per connection box: 4 x mux21 (1 bit) + 3 x mux41 (2 bits).
    localparam int CB_FRAME_W = 10;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    // Field layout within one frame.
    localparam int CB_MUX21_LSB   = 0;   // bits [3:0], one bit per mux21
    localparam int CB_MUX21_W     = 4;
    localparam int CB_MUX41_0_LSB = 4;   // bits [5:4]
    localparam int CB_MUX41_1_LSB = 6;   // bits [7:6]
    localparam int CB_MUX41_2_LSB = 8;   // bits [9:8]
    localparam int CB_MUX41_W     = 2;

endpackage
`default_nettype wire

// File: rtl/cb_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cb_cfg_bank
//  Description : Shadow frame storage plus the active select register.
//                Frames are written one at a time into the shadow slots;
//                a commit copies the whole shadow into the active register
//                in a single edge so the fabric never sees a partial load.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_wr_en         - write i_wr_data into shadow slot i_wr_idx
//                i_wr_idx        - shadow slot index
//                i_wr_data       - frame data
//                i_commit        - copy shadow into active register
//                o_cb_sel        - active selects, box k at [k*FRAME_W +: FRAME_W]
//  Revision    : 1.0  initial release
// ============================================================================
module cb_cfg_bank
    import cb_cfg_pkg::*;
#(
    parameter int NUM_CB  = 4,
    parameter int FRAME_W = CB_FRAME_W,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic [FRAME_W-1:0]        i_wr_data,
    input  logic                      i_commit,
    output logic [NUM_CB*FRAME_W-1:0] o_cb_sel
);

    logic [FRAME_W-1:0]        r_shadow [NUM_CB];
    logic [NUM_CB*FRAME_W-1:0] w_shadow_flat;
    logic [NUM_CB*FRAME_W-1:0] r_active;

    generate
        for (genvar k = 0; k < NUM_CB; k++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shadow[k] <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    r_shadow[k] <= i_wr_data;
                end
            end

            assign w_shadow_flat[k*FRAME_W +: FRAME_W] = r_shadow[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else if (i_commit) begin
            r_active <= w_shadow_flat;
        end
    end

    assign o_cb_sel = r_active;

endmodule
`default_nettype wire

// File: rtl/cb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cb_config_loader
//  Description : Configuration controller for a chain of NUM_CB connection
//                boxes. Accepts one select frame per box over a valid/ready
//                stream, stages them in a shadow bank and commits all of
//                them at once to cb_sel after the last frame.
//  Option      : CB_CFG_PARITY_EN - adds cfg_parity input; frames must have
//                even parity over {cfg_data, cfg_parity}. A bad frame parks
//                the controller in ERROR with cfg_err set until cfg_start.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                cfg_start       - begin / restart a load sequence
//                cfg_valid       - cfg_data holds a frame
//                cfg_data        - frame for box frame_idx
//                cfg_parity      - frame parity bit (option only)
//                cfg_ready       - frame accepted this cycle when valid
//                busy            - controller not idle
//                frame_idx       - index of next expected frame
//                cfg_done        - one-cycle pulse: new configuration active
//                cfg_err         - sticky parity error flag
//                cb_sel          - active selects for all boxes
//  Revision    : 1.0  initial release
// ============================================================================
module cb_config_loader
    import cb_cfg_pkg::*;
#(
    parameter  int NUM_CB  = 4,
    parameter  int FRAME_W = CB_FRAME_W,
    localparam int IDX_W   = (NUM_CB > 1) ? $clog2(NUM_CB) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic [FRAME_W-1:0]        cfg_data,
`ifdef CB_CFG_PARITY_EN
    input  logic                      cfg_parity,
`endif
    output logic                      cfg_ready,
    output logic                      busy,
    output logic [IDX_W-1:0]          frame_idx,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic [NUM_CB*FRAME_W-1:0] cb_sel
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_done;
    logic             w_handshake;
    logic             w_last;
    logic             w_parity_ok;
    logic             w_wr_en;
    logic             w_commit;

    assign cfg_ready   = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign w_handshake = cfg_valid & cfg_ready;
    assign w_last      = (r_idx == IDX_W'(NUM_CB - 1));

`ifdef CB_CFG_PARITY_EN
    assign w_parity_ok = ~(^{cfg_data, cfg_parity});
`else
    assign w_parity_ok = 1'b1;
`endif

    // A restart wins over a simultaneous handshake, so that frame is dropped.
    assign w_wr_en  = w_handshake & ~cfg_start & w_parity_ok;
    assign w_commit = (r_state == ST_COMMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end else if (w_wr_en) begin
                    if (w_last) begin
                        w_state_nxt = ST_COMMIT;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
`ifdef CB_CFG_PARITY_EN
                else if (w_handshake) begin
                    w_state_nxt = ST_ERROR;
                end
`endif
            end
            // Start requests during commit are deliberately not remembered.
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef CB_CFG_PARITY_EN
            ST_ERROR: begin
                if (cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_commit;
        end
    end

`ifdef CB_CFG_PARITY_EN
    logic r_err;

    // The flag simply mirrors residency in ERROR: set on entry, cleared
    // when cfg_start moves the controller back to LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == ST_ERROR);
        end
    end

    assign cfg_err = r_err;
`else
    assign cfg_err = 1'b0;
`endif

    assign frame_idx = r_idx;
    assign cfg_done  = r_done;

    cb_cfg_bank #(
        .NUM_CB  (NUM_CB),
        .FRAME_W (FRAME_W),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_data (cfg_data),
        .i_commit  (w_commit),
        .o_cb_sel  (cb_sel)
    );

endmodule
`default_nettype wire

// File: tb/tb_cb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cb_config_loader
//  Description : Directed self-checking bench for cb_config_loader with a
//                queue of expected committed configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cb_config_loader;

    localparam int NUM_CB  = 4;
    localparam int FRAME_W = 10;
    localparam int IDX_W   = 2;
    localparam int SEL_W   = NUM_CB * FRAME_W;

    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    logic               cfg_start  = 1'b0;
    logic               cfg_valid  = 1'b0;
    logic [FRAME_W-1:0] cfg_data   = '0;
    logic               cfg_parity = 1'b0;
    logic               cfg_ready;
    logic               busy;
    logic [IDX_W-1:0]   frame_idx;
    logic               cfg_done;
    logic               cfg_err;
    logic [SEL_W-1:0]   cb_sel;

    int checks = 0;
    int errors = 0;

    logic [SEL_W-1:0] exp_q [$];
    logic [SEL_W-1:0] active = '0;

    cb_config_loader #(
        .NUM_CB  (NUM_CB),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
`ifdef CB_CFG_PARITY_EN
        .cfg_parity(cfg_parity),
`endif
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .frame_idx (frame_idx),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cb_sel    (cb_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every cfg_done pulse must match the oldest outstanding expected commit.
    always @(negedge clk) begin
        if (!rst && cfg_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done: observed=1 expected=0");
            end else begin
                check("commit_sel", cb_sel, exp_q.pop_front());
            end
        end
    end

    // Drive NUM_CB frames (frame k from frames[k*FRAME_W +: FRAME_W]) and
    // check the commit timing. With gaps, valid drops for one cycle before
    // each frame; with do_start the sequence begins with a cfg_start.
    task automatic load(input logic [SEL_W-1:0] frames, input bit gaps, input bit do_start);
        if (do_start) begin
            cfg_start = 1'b1;
            cfg_valid = 1'b0;
            step();
            cfg_start = 1'b0;
            check("load_busy", busy, 1);
        end
        exp_q.push_back(frames);
        for (int k = 0; k < NUM_CB; k++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                step();
                check("idx_hold", frame_idx, k);
            end
            check("load_ready", cfg_ready, 1);
            check("load_idx", frame_idx, k);
            check("sel_stable", cb_sel, active);
            cfg_valid  = 1'b1;
            cfg_data   = frames[k*FRAME_W +: FRAME_W];
            cfg_parity = ^cfg_data;
            step();
        end
        cfg_valid = 1'b0;
        check("commit_ready_low", cfg_ready, 0);
        check("sel_before_done", cb_sel, active);
        check("done_early", cfg_done, 0);
        step();
        check("done_pulse", cfg_done, 1);
        check("sel_after_commit", cb_sel, frames);
        active = frames;
        step();
        check("done_one_cycle", cfg_done, 0);
        check("idle_after_commit", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEL_W-1:0] cfg_a;
        logic [SEL_W-1:0] cfg_b;
        logic [SEL_W-1:0] cfg_c;
        logic [SEL_W-1:0] cfg_d;
        cfg_a = {10'h001, 10'h2AA, 10'h155, 10'h3FF};
        cfg_b = {10'h0F0, 10'h30C, 10'h0C3, 10'h21A};
        cfg_c = {10'h123, 10'h0AB, 10'h3C0, 10'h05F};
        cfg_d = {10'h111, 10'h222, 10'h333, 10'h044};

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_sel", cb_sel, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_idx", frame_idx, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b0;
        step();

        // Back-to-back load, then the same load with valid gaps
        load(cfg_a, 1'b0, 1'b1);
        load(cfg_a, 1'b1, 1'b1);

        // Restart mid-load: frame coincident with cfg_start is dropped
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = cfg_b[k*FRAME_W +: FRAME_W];
            step();
        end
        check("pre_restart_idx", frame_idx, 2);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 10'h0AA;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_idx", frame_idx, 0);
        check("restart_ready", cfg_ready, 1);
        check("restart_sel", cb_sel, cfg_a);
        load(cfg_b, 1'b0, 1'b0);

        // Reset mid-load clears everything including the active bus
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = cfg_c[k*FRAME_W +: FRAME_W];
            step();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sel", cb_sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cfg_ready, 0);
        check("midrst_idx", frame_idx, 0);
        active = '0;
        load(cfg_c, 1'b0, 1'b1);

        // Valid while idle is ignored
        cfg_valid = 1'b1;
        cfg_data  = 10'h155;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_ready", cfg_ready, 0);
            check("idle_busy", busy, 0);
            check("idle_done", cfg_done, 0);
            check("idle_sel", cb_sel, cfg_c);
        end
        cfg_valid = 1'b0;
        step();

`ifdef CB_CFG_PARITY_EN
        // Parity error on frame 1 parks the controller in ERROR
        cfg_start = 1'b1;
        step();
        cfg_start  = 1'b0;
        cfg_valid  = 1'b1;
        cfg_data   = 10'h3FF;
        cfg_parity = 1'b0;
        step();
        cfg_data   = 10'h001;
        cfg_parity = 1'b0;
        step();
        cfg_valid = 1'b0;
        check("perr_err", cfg_err, 1);
        check("perr_ready", cfg_ready, 0);
        check("perr_busy", busy, 1);
        check("perr_sel", cb_sel, cfg_c);
        step();
        step();
        check("perr_err_sticky", cfg_err, 1);
        check("perr_no_done", cfg_done, 0);
        check("perr_sel_hold", cb_sel, cfg_c);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("perr_clear", cfg_err, 0);
        check("perr_reload_ready", cfg_ready, 1);
        check("perr_reload_idx", frame_idx, 0);
        load(cfg_d, 1'b0, 1'b0);
        check("perr_final_err", cfg_err, 0);
`else
        check("err_tied_low", cfg_err, 0);
        load(cfg_d, 1'b0, 1'b1);
`endif

        step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
